// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared SSD1306 IIC word constants and packing helper
package oled_pkg;

   localparam logic [7:0] OLED_SLAVE_ADDR = 8'h78;
   localparam logic [7:0] OLED_CTRL_CMD   = 8'h00;
   localparam logic [7:0] OLED_CTRL_DATA  = 8'h40;
   localparam logic [7:0] OLED_CMD_PAGE   = 8'hB0;
   localparam logic [7:0] OLED_CMD_COL_LO = 8'h00;
   localparam logic [7:0] OLED_CMD_COL_HI = 8'h10;

   localparam int OLED_WORD_W      = 24;
   localparam int OLED_SLAVE_MSB   = 23;
   localparam int OLED_SLAVE_LSB   = 16;
   localparam int OLED_CTRL_MSB    = 15;
   localparam int OLED_CTRL_LSB    = 8;
   localparam int OLED_PAYLOAD_MSB = 7;
   localparam int OLED_PAYLOAD_LSB = 0;

   function automatic logic [OLED_WORD_W-1:0] oled_word(input logic [7:0] slave,
                                                        input logic [7:0] ctrl,
                                                        input logic [7:0] payload);
      logic [OLED_WORD_W-1:0] w;
      w = '0;
      w[OLED_SLAVE_MSB:OLED_SLAVE_LSB]     = slave;
      w[OLED_CTRL_MSB:OLED_CTRL_LSB]       = ctrl;
      w[OLED_PAYLOAD_MSB:OLED_PAYLOAD_LSB] = payload;
      return w;
   endfunction

endpackage

// File: rtl/oled_frame_refresh.sv
// rtl/oled_frame_refresh.sv - streams a framebuffer to the OLED as page/column commands plus data bytes
module oled_frame_refresh
   import oled_pkg::*;
#(
   parameter logic [7:0] SLAVE_ADDR = OLED_SLAVE_ADDR,
   parameter int          PAGES      = 8,
   parameter int          COLS       = 128,
   parameter logic [7:0] COL_OFFSET = 8'd0
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [9:0]  fb_addr,
   input  logic [7:0]  fb_data,
   output logic        wr_req,
   output logic [23:0] wr_data,
   input  logic        wr_done
);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_FETCH, S_DATA, S_GAP} state_t;

   localparam logic [3:0] LAST_PAGE = 4'(PAGES - 1);
   localparam logic [7:0] LAST_COL  = 8'(COLS - 1);
   localparam logic [9:0] COLS_W    = 10'(COLS);

   state_t      state, state_nxt;
   logic [3:0]  page;
   logic [7:0]  col;
   logic [1:0]  cmd_idx;
   logic        gap_cmd;
   logic        first_data;
   logic [7:0]  payload;
   logic [7:0]  cmd_byte;
   logic        last_byte;

   assign last_byte = (state == S_GAP) && !gap_cmd && (col == LAST_COL) && (page == LAST_PAGE);
   assign fb_addr   = {6'd0, page} * COLS_W + {2'd0, col};

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CMD;
         S_CMD:   if (wr_done) state_nxt = S_GAP;
         S_FETCH: state_nxt = S_DATA;
         S_DATA:  if (wr_done) state_nxt = S_GAP;
         S_GAP: begin
            if (gap_cmd)               state_nxt = (cmd_idx == 2'd2) ? S_FETCH : S_CMD;
            else if (col != LAST_COL)  state_nxt = S_FETCH;
            else if (page != LAST_PAGE) state_nxt = S_CMD;
            else                       state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counters advance only in GAP so every word's fields stay put while wr_req is high.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         page       <= '0;
         col        <= '0;
         cmd_idx    <= '0;
         gap_cmd    <= 1'b0;
         first_data <= 1'b0;
         payload    <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               page    <= '0;
               col     <= '0;
               cmd_idx <= '0;
               gap_cmd <= 1'b0;
            end
            S_CMD: if (wr_done) gap_cmd <= 1'b1;
            S_FETCH: first_data <= 1'b1;
            S_DATA: begin
               first_data <= 1'b0;
               if (first_data) payload <= fb_data;
               if (wr_done) gap_cmd <= 1'b0;
            end
            S_GAP: begin
               if (gap_cmd) begin
                  cmd_idx <= cmd_idx + 2'd1;
               end else if (col != LAST_COL) begin
                  col <= col + 8'd1;
               end else if (page != LAST_PAGE) begin
                  col     <= '0;
                  page    <= page + 4'd1;
                  cmd_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // The RAM byte is only valid in the first DATA cycle; after that the latched copy is used.
   always_comb begin
      busy    = (state != S_IDLE);
      done    = 1'b0;
      wr_req  = 1'b0;
      wr_data = '0;
      case (cmd_idx)
         2'd0:    cmd_byte = OLED_CMD_PAGE | {4'd0, page};
         2'd1:    cmd_byte = OLED_CMD_COL_LO | {4'd0, COL_OFFSET[3:0]};
         default: cmd_byte = OLED_CMD_COL_HI | {4'd0, COL_OFFSET[7:4]};
      endcase
      case (state)
         S_CMD: begin
            wr_req  = 1'b1;
            wr_data = oled_word(SLAVE_ADDR, OLED_CTRL_CMD, cmd_byte);
         end
         S_DATA: begin
            wr_req  = 1'b1;
            wr_data = oled_word(SLAVE_ADDR, OLED_CTRL_DATA, first_data ? fb_data : payload);
         end
         S_GAP: if (last_byte) begin
            done = 1'b1;
            busy = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oled_frame_refresh.sv
// tb/tb_oled_frame_refresh.sv - directed bench for oled_frame_refresh
module tb_oled_frame_refresh;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic        start2  = 1'b0;
   logic        inject  = 1'b0;
   logic        busy, done, wr_req, wr_done;
   logic        busy2, done2, wr_req2, wr_done2;
   logic [9:0]  fb_addr, fb_addr2;
   logic [7:0]  fb_data, fb_data2;
   logic [23:0] wr_data, wr_data2;
   logic [7:0]  fb_mem [0:1023];

   logic        md = 1'b0, md2 = 1'b0;
   int          cnt = 0, cnt2 = 0;
   logic [23:0] cap[$];
   logic [23:0] cap2[$];
   int          done_cnt = 0, done_cnt2 = 0, stab_err = 0, done_busy_err = 0;
   logic        req_q = 1'b0;
   logic [23:0] data_q = '0;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   oled_frame_refresh dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .fb_addr(fb_addr), .fb_data(fb_data), .wr_req(wr_req), .wr_data(wr_data), .wr_done(wr_done)
   );

   oled_frame_refresh #(.PAGES(2), .COLS(4), .COL_OFFSET(8'h02)) dut2 (
      .sys_clk(sys_clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
      .fb_addr(fb_addr2), .fb_data(fb_data2), .wr_req(wr_req2), .wr_data(wr_data2), .wr_done(wr_done2)
   );

   assign wr_done  = md | inject;
   assign wr_done2 = md2;

   always @(posedge sys_clk) begin
      fb_data  <= fb_mem[fb_addr];
      fb_data2 <= fb_mem[fb_addr2];
   end

   // IIC driver model: ack after 5 cycles of wr_req, capturing the acked word
   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         md <= 1'b0; cnt <= 0; md2 <= 1'b0; cnt2 <= 0;
      end else begin
         md  <= 1'b0;
         md2 <= 1'b0;
         if (wr_req && !md) begin
            if (cnt == 4) begin md <= 1'b1; cnt <= 0; cap.push_back(wr_data); end
            else cnt <= cnt + 1;
         end else cnt <= 0;
         if (wr_req2 && !md2) begin
            if (cnt2 == 4) begin md2 <= 1'b1; cnt2 <= 0; cap2.push_back(wr_data2); end
            else cnt2 <= cnt2 + 1;
         end else cnt2 <= 0;
      end
   end

   always @(posedge sys_clk) begin
      req_q  <= wr_req;
      data_q <= wr_data;
      if (req_q && wr_req && wr_data !== data_q) stab_err <= stab_err + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (done2) done_cnt2 <= done_cnt2 + 1;
      if (done && busy) done_busy_err <= done_busy_err + 1;
   end

   function automatic logic [23:0] exp_word(input int idx);
      int p, k;
      p = idx / 131;
      k = idx % 131;
      if (k == 0)      return {16'h7800, 8'hB0 | 8'(p)};
      else if (k == 1) return 24'h780000;
      else if (k == 2) return 24'h780010;
      else             return {16'h7840, fb_mem[p * 128 + k - 3]};
   endfunction

   task automatic wait_done(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge sys_clk);
         if ((which == 0 && done) || (which == 1 && done2)) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (wr_done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req got %0b want 0", wr_req); end
      checks++; if (wr_data !== 24'h0) begin errors++; $display("FAIL reset_wr_data got %h want 000000", wr_data); end
      checks++; if (fb_addr !== 10'h0) begin errors++; $display("FAIL reset_fb_addr got %h want 000", fb_addr); end
      rst_n = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_full_frame;
      int base, dbase, sbase, n;
      bit ok;
      base = cap.size(); dbase = done_cnt; sbase = stab_err;
      start = 1'b1; @(negedge sys_clk); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %0b want 1", busy); end
      checks++; if (wr_req !== 1'b1 || wr_data !== 24'h7800B0)
         begin errors++; $display("FAIL start_first_cmd got req=%0b %h want req=1 7800B0", wr_req, wr_data); end
      wait_ack(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ack1_timeout got none want wr_done"); end
      @(negedge sys_clk);
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL gap_after_cmd got %0b want 0", wr_req); end
      @(negedge sys_clk);
      checks++; if (wr_req !== 1'b1 || wr_data !== 24'h780000)
         begin errors++; $display("FAIL second_cmd got req=%0b %h want req=1 780000", wr_req, wr_data); end
      for (int k = 0; k < 3; k++) wait_ack(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ack4_timeout got none want wr_done"); end
      @(negedge sys_clk);
      @(negedge sys_clk);
      checks++; if (fb_addr !== 10'd1 || wr_req !== 1'b0)
         begin errors++; $display("FAIL fetch_col1 got addr=%0d req=%0b want addr=1 req=0", fb_addr, wr_req); end
      @(negedge sys_clk);
      checks++; if (wr_req !== 1'b1 || wr_data !== 24'h78400A)
         begin errors++; $display("FAIL data_col1 got req=%0b %h want req=1 78400A", wr_req, wr_data); end
      wait_done(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got no done want done"); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_with_done got %0b want 0", busy); end
      repeat (3) @(negedge sys_clk);
      n = cap.size() - base;
      checks++; if (n != 1048) begin errors++; $display("FAIL frame_word_count got %0d want 1048", n); end
      if (n == 1048) begin
         for (int i = 0; i < 1048; i++) begin
            checks++;
            if (cap[base + i] !== exp_word(i))
               begin errors++; $display("FAIL frame_word[%0d] got %h want %h", i, cap[base + i], exp_word(i)); end
         end
         checks++; if (cap[base + 917] !== 24'h7800B7) begin errors++; $display("FAIL page7_cmd got %h want 7800B7", cap[base + 917]); end
         checks++; if (cap[base + 1047] !== 24'h7840A5) begin errors++; $display("FAIL last_word got %h want 7840A5", cap[base + 1047]); end
         checks++; if (cap[base + 3] !== 24'h784003) begin errors++; $display("FAIL first_data got %h want 784003", cap[base + 3]); end
      end
      checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL done_pulses got %0d want 1", done_cnt - dbase); end
      checks++; if (stab_err != sbase) begin errors++; $display("FAIL wr_data_stable got %0d changes want 0", stab_err - sbase); end
      checks++; if (done_busy_err != 0) begin errors++; $display("FAIL done_busy_overlap got %0d want 0", done_busy_err); end
   endtask

   task automatic test_mid_start_spurious;
      int base, dbase, n;
      bit ok, seen;
      base = cap.size(); dbase = done_cnt;
      start = 1'b1; @(negedge sys_clk); start = 1'b0;
      repeat (200) @(negedge sys_clk);
      start = 1'b1; @(negedge sys_clk); start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (wr_req === 1'b0) begin
            seen = 1'b1;
            inject = 1'b1; @(negedge sys_clk); inject = 1'b0;
         end else @(negedge sys_clk);
      end
      checks++; if (!seen) begin errors++; $display("FAIL spurious_slot got none want wr_req low"); end
      wait_done(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got no done want done"); end
      repeat (3) @(negedge sys_clk);
      n = cap.size() - base;
      checks++; if (n != 1048) begin errors++; $display("FAIL mid_word_count got %0d want 1048", n); end
      if (n == 1048) begin
         for (int i = 0; i < 1048; i++) begin
            checks++;
            if (cap[base + i] !== exp_word(i))
               begin errors++; $display("FAIL mid_word[%0d] got %h want %h", i, cap[base + i], exp_word(i)); end
         end
      end
      checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL mid_done_pulses got %0d want 1", done_cnt - dbase); end
   endtask

   task automatic test_reset_mid;
      int base, dbase, n;
      bit ok;
      base = cap.size(); dbase = done_cnt;
      start = 1'b1; @(negedge sys_clk); start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge sys_clk);
         if (cap.size() - base >= 3 * 131 + 13) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("FAIL page3_timeout got %0d words want 406", cap.size() - base); end
      rst_n = 1'b0;
      #1;
      checks++; if (wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL async_reset got req=%0b busy=%0b done=%0b want 0 0 0", wr_req, busy, done); end
      @(negedge sys_clk); rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++; if (done_cnt != dbase) begin errors++; $display("FAIL reset_no_done got %0d want 0", done_cnt - dbase); end
      base = cap.size(); dbase = done_cnt;
      start = 1'b1; @(negedge sys_clk); start = 1'b0;
      checks++; if (wr_req !== 1'b1 || wr_data !== 24'h7800B0)
         begin errors++; $display("FAIL restart_cmd got req=%0b %h want req=1 7800B0", wr_req, wr_data); end
      wait_done(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got no done want done"); end
      repeat (3) @(negedge sys_clk);
      n = cap.size() - base;
      checks++; if (n != 1048) begin errors++; $display("FAIL restart_word_count got %0d want 1048", n); end
      checks++; if (cap[base + 418] !== exp_word(418))
         begin errors++; $display("FAIL restart_page3_word got %h want %h", cap[base + 418], exp_word(418)); end
      checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt - dbase); end
   endtask

   task automatic test_back_to_back;
      int base, base2, n;
      bit ok;
      base = cap.size();
      start = 1'b1; @(negedge sys_clk); start = 1'b0;
      wait_done(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got no done want done"); end
      start = 1'b1;
      @(negedge sys_clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_cycle got busy=%0b want 0", busy); end
      @(negedge sys_clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1 || wr_data !== 24'h7800B0)
         begin errors++; $display("FAIL b2b_accept got busy=%0b %h want busy=1 7800B0", busy, wr_data); end
      base2 = cap.size();
      wait_done(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got no done want done"); end
      repeat (3) @(negedge sys_clk);
      n = cap.size() - base2;
      checks++; if (n != 1048 || base2 - base != 1048)
         begin errors++; $display("FAIL b2b_counts got %0d and %0d want 1048 and 1048", base2 - base, n); end
      if (n == 1048) begin
         for (int i = 0; i < 1048; i++) begin
            checks++;
            if (cap[base2 + i] !== exp_word(i))
               begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", i, cap[base2 + i], exp_word(i)); end
         end
      end
   endtask

   task automatic test_col_offset;
      logic [23:0] exp_tbl [14];
      int dbase;
      bit ok;
      exp_tbl = '{24'h7800B0, 24'h780002, 24'h780010, 24'h784003, 24'h78400A, 24'h784011, 24'h784018,
                  24'h7800B1, 24'h780002, 24'h780010, 24'h78401F, 24'h784026, 24'h78402D, 24'h784034};
      dbase = done_cnt2;
      start2 = 1'b1; @(negedge sys_clk); start2 = 1'b0;
      wait_done(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL offset_timeout got no done want done"); end
      repeat (3) @(negedge sys_clk);
      checks++; if (cap2.size() != 14) begin errors++; $display("FAIL offset_word_count got %0d want 14", cap2.size()); end
      if (cap2.size() == 14) begin
         for (int i = 0; i < 14; i++) begin
            checks++;
            if (cap2[i] !== exp_tbl[i])
               begin errors++; $display("FAIL offset_word[%0d] got %h want %h", i, cap2[i], exp_tbl[i]); end
         end
      end
      checks++; if (done_cnt2 - dbase != 1) begin errors++; $display("FAIL offset_done got %0d want 1", done_cnt2 - dbase); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) fb_mem[i] = 8'(i * 7 + 3);
      fb_mem[1023] = 8'hA5;
      test_reset;
      test_full_frame;
      test_mid_start_spurious;
      test_reset_mid;
      test_back_to_back;
      test_col_offset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
